pipe_sequencer: RTL and testbench
=================================

# pipe_sequencer

Pipeline sequencer for the 4-stage CPU. Generates `enable_regwalls`, `do_hazard`, `do_flush_REG1` and `enable_pc` from memory readiness, load-use detection and decode-stage branch resolution. Holds the pipeline through post-reset boot and memory wait states, and flags a sticky timeout when a wait runs too long. Sits beside the pipeline register walls in the CPU top level.

## Interface
- `BOOT_CYCLES`, 2: cycles the pipeline stays frozen after reset; must be ≥1.
- `WAIT_TIMEOUT`, 255: consecutive wait cycles before the timeout flag sets; 1..255.
- `clock`  in  1  single clock; all state updates on its falling edge, matching the register walls.
- `reset`  in  1  synchronous, active-high.
- `iIM_ready`  in  1  instruction memory delivers the fetch this cycle.
- `iDM_req`  in  1  MEM stage issues a data read or write.
- `iDM_ready`  in  1  data memory completes the access this cycle.
- `iID_rs_addr`, `iID_rt_addr`  in  5  decode source register addresses.
- `iID_rs_used`, `iID_rt_used`  in  1  decode instruction reads rs / rt.
- `iEX_do_dm_read`  in  1  EX-stage instruction is a load.
- `iEX_write_reg_addr`  in  5  EX-stage destination register.
- `iID_do_branch`  in  1  taken branch or jump resolved in decode.
- `enable_regwalls`  out  1  advance all pipeline walls.
- `do_hazard`  out  1  load-use bubble request.
- `do_flush_REG1`  out  1  squash the IF/ID wall.
- `enable_pc`  out  1  PC may update.
- `oState`  out  2  current FSM state.
- `oWait_timeout`  out  1  sticky wait-timeout flag.
- `oPerf_stall_cnt`, `oPerf_hazard_cnt`, `oPerf_flush_cnt`  out  32 each  performance counters.

## Operation
- States: BOOT=0, RUN=1, IM_WAIT=2, DM_WAIT=3.
- `dm_ok` = !iDM_req || iDM_ready.
- `go` = (state != BOOT) && dm_ok && iIM_ready && !reset.
- Load-use: `lu` = iEX_do_dm_read && iEX_write_reg_addr≠0 && ((iID_rs_used && iID_rs_addr==iEX_write_reg_addr) || (iID_rt_used && iID_rt_addr==iEX_write_reg_addr)).
- Outputs (combinational from state and inputs):
  - `enable_regwalls` = go.
  - `do_hazard` = lu && state≠BOOT && !reset.
  - `do_flush_REG1` = iID_do_branch && !do_hazard && state≠BOOT && !reset.
  - `enable_pc` = go && !do_hazard.
- Transitions:
  - BOOT: boot_cnt increments each cycle; at boot_cnt==BOOT_CYCLES-1, go to RUN.
  - RUN / IM_WAIT / DM_WAIT: if !dm_ok, go to DM_WAIT; else if !iIM_ready, go to IM_WAIT; else go to RUN.
  - DM wait has priority over IM wait.
- Wait counter: increments while state ∈ {IM_WAIT, DM_WAIT} and !go; clears on any go cycle. When it reaches WAIT_TIMEOUT, `oWait_timeout` sets and holds until reset. The counter saturates.
- A branch asserted during a stall stays asserted because ID is frozen. The flush takes effect on the first go cycle.
- Hazard and flush together: hazard wins and the flush is suppressed. The branch re-resolves after the bubble.

## Timing
- While `reset` is high: all outputs are 0. On the reset edge: state=BOOT, boot_cnt=0, wait_cnt=0, `oWait_timeout`=0, perf counters=0.
- After reset deasserts: BOOT_CYCLES falling edges with `enable_regwalls`=0, then RUN. The first possible go is in cycle BOOT_CYCLES.
- Zero-cycle latency from `iIM_ready`/`iDM_ready` to `enable_regwalls`. A ready arriving in a wait state advances the pipeline in that same cycle.
- Reset mid-wait: returns to BOOT immediately and the timeout flag clears.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `oPerf_stall_cnt` counts cycles with state≠BOOT and !go.
  - `oPerf_hazard_cnt` counts go cycles with do_hazard.
  - `oPerf_flush_cnt` counts go cycles with do_flush_REG1.
  - All three saturate at 32'hFFFF_FFFF.
- Not defined: the counters are not instantiated and all three ports are driven to 0.

## Structure
- `pipe_ctrl_pkg` holds the state encoding localparams (BOOT/RUN/IM_WAIT/DM_WAIT) and the perf counter width.
- Sub-module `hazard_detect`: purely combinational load-use compare producing `lu`.

## Test plan
- BOOT: reset high 3 cycles, then low → `enable_regwalls`=0 for exactly 2 cycles, then 1; `oState` goes 0→1.
- DM wait: iDM_req=1 with iDM_ready=0 for 4 cycles → `oState`=3, enable=0 for 4 cycles; on the ready cycle enable=1; `oPerf_stall_cnt`=4 when the macro is on.
- Load-use: iEX_do_dm_read=1, iEX_write_reg_addr=5, iID_rt_addr=5, iID_rt_used=1 → do_hazard=1, enable_pc=0, enable_regwalls=1. Same case with address 0 → do_hazard=0.
- Branch plus hazard: iID_do_branch=1 with lu=1 → flush=0; next cycle with lu=0 → flush=1.
- Timeout: WAIT_TIMEOUT=3, iIM_ready=0 for 5 cycles → `oWait_timeout` rises on the 3rd wait cycle and stays 1 after the ready returns; reset clears it.
- Simultaneous DM and IM wait: iDM_req=1, iDM_ready=0, iIM_ready=0 → `oState`=3. Then DM ready with IM still not ready → `oState`=2, enable=0.

Source files
------------

// File: rtl/pipe_sequencer_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, counter widths and
// a saturating-increment helper for the performance counters.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_BOOT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_IM_WAIT = 2'd2;
  localparam logic [1:0] ST_DM_WAIT = 2'd3;

  typedef enum logic [1:0] {
    S_BOOT    = ST_BOOT,
    S_RUN     = ST_RUN,
    S_IM_WAIT = ST_IM_WAIT,
    S_DM_WAIT = ST_DM_WAIT
  } state_e;

  localparam int PERF_CNT_W = 32;
  localparam int WAIT_CNT_W = 8;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                    input logic                  en);
    return (en && (v != {PERF_CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// Memory-handshake and pipeline-control bundle between the CPU datapath
// (master) and the sequencer (slave).
interface pipe_sequencer_if;
  logic iIM_ready;
  logic iDM_req;
  logic iDM_ready;
  logic enable_regwalls;
  logic do_hazard;
  logic do_flush_REG1;
  logic enable_pc;

  modport master (
    output iIM_ready, iDM_req, iDM_ready,
    input  enable_regwalls, do_hazard, do_flush_REG1, enable_pc
  );

  modport slave (
    input  iIM_ready, iDM_req, iDM_ready,
    output enable_regwalls, do_hazard, do_flush_REG1, enable_pc
  );
endinterface

// File: rtl/pipe_sequencer_hazard_detect.sv
// Load-use detector: an EX-stage load whose destination feeds a decode-stage
// source operand. Register 0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  input  logic       id_rs_used_i,
  input  logic       id_rt_used_i,
  input  logic       ex_do_dm_read_i,
  input  logic [4:0] ex_write_reg_addr_i,
  output logic       lu_o
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used_i && (id_rs_addr_i == ex_write_reg_addr_i);
  assign rt_hit = id_rt_used_i && (id_rt_addr_i == ex_write_reg_addr_i);
  assign lu_o   = ex_do_dm_read_i && (ex_write_reg_addr_i != 5'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: boot freeze, memory wait states, load-use bubbles and
// branch flushes. Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  pipe_sequencer_if.slave       seq_if,
  input  logic [4:0]            iID_rs_addr,
  input  logic [4:0]            iID_rt_addr,
  input  logic                  iID_rs_used,
  input  logic                  iID_rt_used,
  input  logic                  iEX_do_dm_read,
  input  logic [4:0]            iEX_write_reg_addr,
  input  logic                  iID_do_branch,
  output logic [1:0]            oState,
  output logic                  oWait_timeout,
  output logic [PERF_CNT_W-1:0] oPerf_stall_cnt,
  output logic [PERF_CNT_W-1:0] oPerf_hazard_cnt,
  output logic [PERF_CNT_W-1:0] oPerf_flush_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;

  logic lu;
  logic dm_ok;
  logic not_boot;
  logic in_wait;
  logic go;
  logic hazard;
  logic flush;

  hazard_detect u_hazard_detect (
    .id_rs_addr_i        (iID_rs_addr),
    .id_rt_addr_i        (iID_rt_addr),
    .id_rs_used_i        (iID_rs_used),
    .id_rt_used_i        (iID_rt_used),
    .ex_do_dm_read_i     (iEX_do_dm_read),
    .ex_write_reg_addr_i (iEX_write_reg_addr),
    .lu_o                (lu)
  );

  assign dm_ok    = !seq_if.iDM_req || seq_if.iDM_ready;
  assign not_boot = (state_q != S_BOOT);
  assign in_wait  = (state_q == S_IM_WAIT) || (state_q == S_DM_WAIT);
  assign go       = not_boot && dm_ok && seq_if.iIM_ready && !reset;
  // Hazard beats flush: the branch re-resolves once the bubble has passed.
  assign hazard   = lu && not_boot && !reset;
  assign flush    = iID_do_branch && !hazard && not_boot && !reset;

  assign seq_if.enable_regwalls = go;
  assign seq_if.do_hazard       = hazard;
  assign seq_if.do_flush_REG1   = flush;
  assign seq_if.enable_pc       = go && !hazard;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_IM_WAIT, S_DM_WAIT: begin
        if (!dm_ok) begin
          state_d = S_DM_WAIT;
        end else if (!seq_if.iIM_ready) begin
          state_d = S_IM_WAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (go) begin
      wait_cnt_d = '0;
    end else if (in_wait && (wait_cnt_q != {WAIT_CNT_W{1'b1}})) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q || (wait_cnt_d >= WAIT_CNT_W'(WAIT_TIMEOUT));
  end

  // Everything commits on the falling edge, in step with the register walls.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign oState        = reset ? ST_BOOT : state_q;
  assign oWait_timeout = timeout_q && !reset;

`ifdef PIPE_PERF_CNT_EN
  logic [2:0]            perf_inc;
  logic [PERF_CNT_W-1:0] perf_val [3];

  assign perf_inc[0] = not_boot && !go && !reset;
  assign perf_inc[1] = go && hazard;
  assign perf_inc[2] = go && flush;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d        = sat_inc(cnt_q, perf_inc[gi]);
    assign perf_val[gi] = cnt_q;

    always_ff @(negedge clock) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign oPerf_stall_cnt  = reset ? '0 : perf_val[0];
  assign oPerf_hazard_cnt = reset ? '0 : perf_val[1];
  assign oPerf_flush_cnt  = reset ? '0 : perf_val[2];
`else
  assign oPerf_stall_cnt  = '0;
  assign oPerf_hazard_cnt = '0;
  assign oPerf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer (BOOT_CYCLES=2, WAIT_TIMEOUT=3); inputs
// change just after the rising edge, the DUT commits on the falling edge.
module tb_pipe_sequencer;

  logic        clock;
  logic        reset;
  logic [4:0]  iID_rs_addr, iID_rt_addr, iEX_write_reg_addr;
  logic        iID_rs_used, iID_rt_used, iEX_do_dm_read, iID_do_branch;
  logic [1:0]  oState;
  logic        oWait_timeout;
  logic [31:0] oPerf_stall_cnt, oPerf_hazard_cnt, oPerf_flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_sequencer_if bus ();

  pipe_sequencer #(.BOOT_CYCLES(2), .WAIT_TIMEOUT(3)) dut (
    .clock              (clock),
    .reset              (reset),
    .seq_if             (bus.slave),
    .iID_rs_addr        (iID_rs_addr),
    .iID_rt_addr        (iID_rt_addr),
    .iID_rs_used        (iID_rs_used),
    .iID_rt_used        (iID_rt_used),
    .iEX_do_dm_read     (iEX_do_dm_read),
    .iEX_write_reg_addr (iEX_write_reg_addr),
    .iID_do_branch      (iID_do_branch),
    .oState             (oState),
    .oWait_timeout      (oWait_timeout),
    .oPerf_stall_cnt    (oPerf_stall_cnt),
    .oPerf_hazard_cnt   (oPerf_hazard_cnt),
    .oPerf_flush_cnt    (oPerf_flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    bus.iIM_ready      = 1'b1;
    bus.iDM_req        = 1'b0;
    bus.iDM_ready      = 1'b0;
    iID_rs_addr        = 5'd0;
    iID_rt_addr        = 5'd0;
    iID_rs_used        = 1'b0;
    iID_rt_used        = 1'b0;
    iEX_do_dm_read     = 1'b0;
    iEX_write_reg_addr = 5'd0;
    iID_do_branch      = 1'b0;
  endtask

  // Leaves the bench at the start of the first RUN cycle.
  task automatic reset_and_boot();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset              = 1'b1;
    iEX_do_dm_read     = 1'b1;
    iEX_write_reg_addr = 5'd5;
    iID_rt_addr        = 5'd5;
    iID_rt_used        = 1'b1;
    iID_do_branch      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if ({bus.enable_regwalls, bus.do_hazard, bus.do_flush_REG1, bus.enable_pc} !== 4'b0000) begin
        $display("FAIL reset_outs cyc%0d got %b want 0000", i,
                 {bus.enable_regwalls, bus.do_hazard, bus.do_flush_REG1, bus.enable_pc});
        n_bad++;
      end
      n_vec++;
      if (oState !== 2'd0) begin
        $display("FAIL reset_state got %0d want 0", oState); n_bad++;
      end
      n_vec++;
      tick();
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if ({bus.enable_regwalls, bus.do_hazard, bus.do_flush_REG1, bus.enable_pc} !== 4'b0000) begin
        $display("FAIL boot_outs cyc%0d got %b want 0000", i,
                 {bus.enable_regwalls, bus.do_hazard, bus.do_flush_REG1, bus.enable_pc});
        n_bad++;
      end
      n_vec++;
      if (oState !== 2'd0) begin
        $display("FAIL boot_state cyc%0d got %0d want 0", i, oState); n_bad++;
      end
      n_vec++;
      tick();
    end
    set_idle();
    #1;
    if (bus.enable_regwalls !== 1'b1 || bus.enable_pc !== 1'b1) begin
      $display("FAIL run_enable got %b%b want 11", bus.enable_regwalls, bus.enable_pc); n_bad++;
    end
    n_vec++;
    if (oState !== 2'd1) begin
      $display("FAIL run_state got %0d want 1", oState); n_bad++;
    end
    n_vec++;
    if (oWait_timeout !== 1'b0 || oPerf_stall_cnt !== 32'd0 || oPerf_hazard_cnt !== 32'd0 ||
        oPerf_flush_cnt !== 32'd0) begin
      $display("FAIL reset_status got to=%b st=%0d hz=%0d fl=%0d want all 0", oWait_timeout,
               oPerf_stall_cnt, oPerf_hazard_cnt, oPerf_flush_cnt);
      n_bad++;
    end
    n_vec++;
    tick();
    $display("test_reset done at %0t", $time);
  endtask

  task automatic test_dm_wait();
    reset_and_boot();
    bus.iDM_req   = 1'b1;
    bus.iDM_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.enable_regwalls !== 1'b0 || bus.enable_pc !== 1'b0) begin
        $display("FAIL dm_stall_en cyc%0d got %b%b want 00", i, bus.enable_regwalls, bus.enable_pc);
        n_bad++;
      end
      n_vec++;
      if (oState !== ((i == 0) ? 2'd1 : 2'd3)) begin
        $display("FAIL dm_stall_state cyc%0d got %0d want %0d", i, oState, (i == 0) ? 1 : 3);
        n_bad++;
      end
      n_vec++;
      tick();
    end
    bus.iDM_ready = 1'b1;
    #1;
    if (bus.enable_regwalls !== 1'b1 || oState !== 2'd3) begin
      $display("FAIL dm_ready got en=%b st=%0d want en=1 st=3", bus.enable_regwalls, oState);
      n_bad++;
    end
    n_vec++;
    if (oWait_timeout !== 1'b1) begin
      $display("FAIL dm_timeout got %b want 1", oWait_timeout); n_bad++;
    end
    n_vec++;
    tick();
    set_idle();
    #1;
    if (oState !== 2'd1) begin
      $display("FAIL dm_back_run got %0d want 1", oState); n_bad++;
    end
    n_vec++;
    if (oPerf_stall_cnt !== (PERF ? 32'd4 : 32'd0)) begin
      $display("FAIL dm_stall_cnt got %0d want %0d", oPerf_stall_cnt, PERF ? 4 : 0); n_bad++;
    end
    n_vec++;
    tick();
    $display("test_dm_wait done at %0t", $time);
  endtask

  task automatic test_load_use();
    // {dm_read, wr, rs, rs_used, rt, rt_used, expected hazard}
    logic [18:0] vecs [5];
    vecs[0] = {1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1};
    vecs[1] = {1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[2] = {1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 1'b1};
    vecs[3] = {1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0};
    vecs[4] = {1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0};
    reset_and_boot();
    for (int i = 0; i < 5; i++) begin
      {iEX_do_dm_read, iEX_write_reg_addr, iID_rs_addr, iID_rs_used, iID_rt_addr, iID_rt_used} = vecs[i][18:1];
      #1;
      if (bus.do_hazard !== vecs[i][0] || bus.enable_pc !== !vecs[i][0] || bus.enable_regwalls !== 1'b1) begin
        $display("FAIL lu_vec%0d got hz=%b pc=%b en=%b want hz=%b pc=%b en=1", i, bus.do_hazard,
                 bus.enable_pc, bus.enable_regwalls, vecs[i][0], !vecs[i][0]);
        n_bad++;
      end
      n_vec++;
      tick();
    end
    set_idle();
    #1;
    if (oPerf_hazard_cnt !== (PERF ? 32'd2 : 32'd0)) begin
      $display("FAIL lu_hazard_cnt got %0d want %0d", oPerf_hazard_cnt, PERF ? 2 : 0); n_bad++;
    end
    n_vec++;
    tick();
    $display("test_load_use done at %0t", $time);
  endtask

  task automatic test_branch_hazard();
    reset_and_boot();
    iID_do_branch      = 1'b1;
    iEX_do_dm_read     = 1'b1;
    iEX_write_reg_addr = 5'd4;
    iID_rs_addr        = 5'd4;
    iID_rs_used        = 1'b1;
    #1;
    if (bus.do_flush_REG1 !== 1'b0 || bus.do_hazard !== 1'b1) begin
      $display("FAIL br_hz got fl=%b hz=%b want fl=0 hz=1", bus.do_flush_REG1, bus.do_hazard); n_bad++;
    end
    n_vec++;
    tick();
    iEX_do_dm_read = 1'b0;
    #1;
    if (bus.do_flush_REG1 !== 1'b1 || bus.do_hazard !== 1'b0 || bus.enable_regwalls !== 1'b1) begin
      $display("FAIL br_after got fl=%b hz=%b en=%b want 101", bus.do_flush_REG1, bus.do_hazard,
               bus.enable_regwalls);
      n_bad++;
    end
    n_vec++;
    tick();
    bus.iIM_ready = 1'b0;
    #1;
    if (bus.do_flush_REG1 !== 1'b1 || bus.enable_regwalls !== 1'b0) begin
      $display("FAIL br_stall got fl=%b en=%b want fl=1 en=0", bus.do_flush_REG1, bus.enable_regwalls);
      n_bad++;
    end
    n_vec++;
    tick();
    bus.iIM_ready = 1'b1;
    #1;
    if (bus.do_flush_REG1 !== 1'b1 || bus.enable_regwalls !== 1'b1 || oState !== 2'd2) begin
      $display("FAIL br_release got fl=%b en=%b st=%0d want fl=1 en=1 st=2", bus.do_flush_REG1,
               bus.enable_regwalls, oState);
      n_bad++;
    end
    n_vec++;
    tick();
    set_idle();
    #1;
    if (oPerf_flush_cnt !== (PERF ? 32'd2 : 32'd0) || oPerf_hazard_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      $display("FAIL br_cnts got fl=%0d hz=%0d want fl=%0d hz=%0d", oPerf_flush_cnt,
               oPerf_hazard_cnt, PERF ? 2 : 0, PERF ? 1 : 0);
      n_bad++;
    end
    n_vec++;
    tick();
    $display("test_branch_hazard done at %0t", $time);
  endtask

  task automatic test_timeout();
    logic [4:0] exp_to;
    exp_to = 5'b10000;  // cycle 4 is the first with the flag visible
    reset_and_boot();
    bus.iIM_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (oWait_timeout !== exp_to[i] || bus.enable_regwalls !== 1'b0) begin
        $display("FAIL to_wait cyc%0d got to=%b en=%b want to=%b en=0", i, oWait_timeout,
                 bus.enable_regwalls, exp_to[i]);
        n_bad++;
      end
      n_vec++;
      tick();
    end
    bus.iIM_ready = 1'b1;
    #1;
    if (oWait_timeout !== 1'b1 || bus.enable_regwalls !== 1'b1 || oState !== 2'd2) begin
      $display("FAIL to_ready got to=%b en=%b st=%0d want to=1 en=1 st=2", oWait_timeout,
               bus.enable_regwalls, oState);
      n_bad++;
    end
    n_vec++;
    tick();
    #1;
    if (oWait_timeout !== 1'b1 || oState !== 2'd1) begin
      $display("FAIL to_sticky got to=%b st=%0d want to=1 st=1", oWait_timeout, oState); n_bad++;
    end
    n_vec++;
    bus.iIM_ready = 1'b0;
    tick();
    tick();
    #1;
    if (oState !== 2'd2) begin
      $display("FAIL to_rewait got %0d want 2", oState); n_bad++;
    end
    n_vec++;
    reset = 1'b1;
    #1;
    if (oState !== 2'd0 || oWait_timeout !== 1'b0 || bus.enable_regwalls !== 1'b0) begin
      $display("FAIL to_reset got st=%0d to=%b en=%b want 0 0 0", oState, oWait_timeout,
               bus.enable_regwalls);
      n_bad++;
    end
    n_vec++;
    tick();
    reset = 1'b0;
    bus.iIM_ready = 1'b1;
    #1;
    if (oState !== 2'd0 || oWait_timeout !== 1'b0 || bus.enable_regwalls !== 1'b0) begin
      $display("FAIL to_after_reset got st=%0d to=%b en=%b want 0 0 0", oState, oWait_timeout,
               bus.enable_regwalls);
      n_bad++;
    end
    n_vec++;
    tick();
    $display("test_timeout done at %0t", $time);
  endtask

  task automatic test_dual_wait();
    reset_and_boot();
    bus.iDM_req   = 1'b1;
    bus.iDM_ready = 1'b0;
    bus.iIM_ready = 1'b0;
    tick();
    #1;
    if (oState !== 2'd3) begin
      $display("FAIL dual_state got %0d want 3", oState); n_bad++;
    end
    n_vec++;
    bus.iDM_ready = 1'b1;
    #1;
    if (bus.enable_regwalls !== 1'b0) begin
      $display("FAIL dual_dm_only got en=%b want 0", bus.enable_regwalls); n_bad++;
    end
    n_vec++;
    tick();
    #1;
    if (oState !== 2'd2 || bus.enable_regwalls !== 1'b0) begin
      $display("FAIL dual_to_im got st=%0d en=%b want st=2 en=0", oState, bus.enable_regwalls);
      n_bad++;
    end
    n_vec++;
    bus.iIM_ready = 1'b1;
    #1;
    if (bus.enable_regwalls !== 1'b1) begin
      $display("FAIL dual_release got en=%b want 1", bus.enable_regwalls); n_bad++;
    end
    n_vec++;
    tick();
    set_idle();
    #1;
    if (oState !== 2'd1) begin
      $display("FAIL dual_run got %0d want 1", oState); n_bad++;
    end
    n_vec++;
    tick();
    $display("test_dual_wait done at %0t", $time);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    tick();
    test_reset();
    test_dm_wait();
    test_load_use();
    test_branch_hazard();
    test_timeout();
    test_dual_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
